// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding select codes
// and the mul/div hold FSM state type.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from M-stage ALU result

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_hold_timer.sv
// Mul/div occupancy timer: holds the E stage for MD_LAT cycles after a
// mul/div enters E. freeze (data-memory wait) suspends the FSM and counter.
module md_hold_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic freeze,
  output logic md_stall
);

  localparam int unsigned CNT_BITS = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  md_state_t           state;
  md_state_t           state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_nxt;

  // State and countdown register, synchronous reset aborts any hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and stall decode; the first stall cycle is the IDLE cycle
  // that sees md_start, the release cycle is BUSY with cnt==0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_stall  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          md_stall = 1'b1;
          if (!freeze) begin
            cnt_nxt   = CNT_BITS'(MD_LAT - 1);
            state_nxt = MD_BUSY;
          end
        end
      end
      MD_BUSY: begin
        if (cnt != '0) begin
          md_stall = 1'b1;
          if (!freeze) begin
            cnt_nxt = cnt - CNT_BITS'(1);
          end
        end else if (!freeze) begin
          state_nxt = MD_IDLE;
        end
      end
      default: begin
        state_nxt = MD_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit for the 5-stage F/D/E/M/W core: forwarding selects,
// per-stage stall/flush, mul/div hold and data-memory-wait freeze.
// Optional perf counters are built when HAZ_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_d,
  input  logic              pc_src_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] rf_a_e,
  input  logic              rf_we_e,
  input  logic              memtoreg_e,
  input  logic              md_start_e,
  input  logic [REG_AW-1:0] rf_a_m,
  input  logic              rf_we_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] rf_a_w,
  input  logic              rf_we_w,
  input  logic              dmem_wait,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  logic md_stall;
  logic lw_stall;
  logic br_stall;
  logic match_e;
  logic match_m;

  // E-stage operand select; the younger M result wins over W.
  function automatic logic [1:0] fwd_e_sel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != '0 && rf_we_m && src == rf_a_m) begin
      sel = FWD_MEM;
    end else if (src != '0 && rf_we_w && src == rf_a_w) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  // Forwarding selects for E operands and the D-stage branch comparator.
  always_comb begin
    fwd_a_e = fwd_e_sel(rs_e);
    fwd_b_e = fwd_e_sel(rt_e);
    fwd_a_d = (rs_d != '0) && rf_we_m && (rs_d == rf_a_m);
    fwd_b_d = (rt_d != '0) && rf_we_m && (rt_d == rf_a_m);
  end

  // Load-use and branch-operand dependency detection against D sources.
  always_comb begin
    match_e  = (rf_a_e == rs_d) || (rf_a_e == rt_d);
    match_m  = (rf_a_m == rs_d) || (rf_a_m == rt_d);
    lw_stall = memtoreg_e && rf_we_e && (rf_a_e != '0) && match_e;
    br_stall = branch_d &&
               ((rf_we_e && (rf_a_e != '0) && match_e) ||
                (memtoreg_m && (rf_a_m != '0) && match_m));
  end

  md_hold_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start_e),
    .freeze   (dmem_wait),
    .md_stall (md_stall)
  );

  // Stall/flush priority: memory wait freezes everything, then mul/div
  // hold, then load-use/branch bubbles; a taken branch kills D unless held.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (dmem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (md_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lw_stall || br_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
    flush_d = pc_src_d && !stall_d;
  end

`ifdef HAZ_PERF_EN
  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_f && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      end
      if ((flush_d || flush_e || flush_m) && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              branch_d, pc_src_d;
  logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e;
  logic [REG_AW-1:0] rf_a_e, rf_a_m, rf_a_w;
  logic              rf_we_e, memtoreg_e, md_start_e;
  logic              rf_we_m, memtoreg_m, rf_we_w, dmem_wait;
  logic [1:0]        fwd_a_e, fwd_b_e;
  logic              fwd_a_d, fwd_b_d;
  logic              stall_f, stall_d, stall_e, stall_m, stall_w;
  logic              flush_d, flush_e, flush_m;
  logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;

  hazard_ctrl #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_d       (branch_d),
    .pc_src_d       (pc_src_d),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .rs_e           (rs_e),
    .rt_e           (rt_e),
    .rf_a_e         (rf_a_e),
    .rf_we_e        (rf_we_e),
    .memtoreg_e     (memtoreg_e),
    .md_start_e     (md_start_e),
    .rf_a_m         (rf_a_m),
    .rf_we_m        (rf_we_m),
    .memtoreg_m     (memtoreg_m),
    .rf_a_w         (rf_a_w),
    .rf_we_w        (rf_we_w),
    .dmem_wait      (dmem_wait),
    .fwd_a_e        (fwd_a_e),
    .fwd_b_e        (fwd_b_e),
    .fwd_a_d        (fwd_a_d),
    .fwd_b_d        (fwd_b_d),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .stall_w        (stall_w),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles elapsed in the current mul/div hold
  // (-1 when no hold is in progress) and expected event counts.
  int     md_elapsed = -1;
  longint ref_stall_cnt = 0;
  longint ref_flush_cnt = 0;
  int     cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd_e(input logic [REG_AW-1:0] src);
    if (src != 0 && rf_we_m && src == rf_a_m) return 2'b10;
    if (src != 0 && rf_we_w && src == rf_a_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic longint sat_inc(input longint v);
    longint top;
    top = (longint'(1) << CNT_W) - 1;
    return (v < top) ? v + 1 : v;
  endfunction

  // Compare combinational outputs for the current inputs, advance the model
  // across the next rising edge, then check the registered counters.
  task automatic step();
    logic md, lw, br, dep_e, dep_m;
    logic [7:0] exp_vec, obs_vec;
    logic exp_sf, exp_sd, exp_se, exp_sm, exp_sw, exp_fd, exp_fe, exp_fm;
    #1;
    md    = (md_elapsed < 0) ? md_start_e : (md_elapsed < int'(MD_LAT));
    dep_e = (rf_a_e == rs_d) || (rf_a_e == rt_d);
    dep_m = (rf_a_m == rs_d) || (rf_a_m == rt_d);
    lw    = memtoreg_e && rf_we_e && rf_a_e != 0 && dep_e;
    br    = branch_d && ((rf_we_e && rf_a_e != 0 && dep_e) ||
                         (memtoreg_m && rf_a_m != 0 && dep_m));
    {exp_sf, exp_sd, exp_se, exp_sm, exp_sw, exp_fe, exp_fm} = 7'b0;
    if (dmem_wait)     {exp_sf, exp_sd, exp_se, exp_sm, exp_sw} = 5'b11111;
    else if (md)       {exp_sf, exp_sd, exp_se, exp_fm} = 4'b1111;
    else if (lw || br) {exp_sf, exp_sd, exp_fe} = 3'b111;
    exp_fd  = pc_src_d && !exp_sd;
    exp_vec = {exp_sf, exp_sd, exp_se, exp_sm, exp_sw, exp_fd, exp_fe, exp_fm};
    obs_vec = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m};
    check("stall_flush", 32'(obs_vec), 32'(exp_vec));
    check("fwd_a_e", 32'(fwd_a_e), 32'(ref_fwd_e(rs_e)));
    check("fwd_b_e", 32'(fwd_b_e), 32'(ref_fwd_e(rt_e)));
    check("fwd_d", 32'({fwd_a_d, fwd_b_d}),
          32'({rs_d != 0 && rf_we_m && rs_d == rf_a_m,
               rt_d != 0 && rf_we_m && rt_d == rf_a_m}));
    if (!rst_n) begin
      md_elapsed    = -1;
      ref_stall_cnt = 0;
      ref_flush_cnt = 0;
    end else begin
      if (!dmem_wait) begin
        if (md_elapsed < 0) md_elapsed = md_start_e ? 1 : -1;
        else if (md_elapsed >= int'(MD_LAT)) md_elapsed = -1;
        else md_elapsed++;
      end
      if (exp_sf) ref_stall_cnt = sat_inc(ref_stall_cnt);
      if (exp_fd || exp_fe || exp_fm) ref_flush_cnt = sat_inc(ref_flush_cnt);
    end
    @(negedge clk);
    cyc++;
`ifdef HAZ_PERF_EN
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'(ref_stall_cnt));
    check("perf_flush_cnt", 32'(perf_flush_cnt), 32'(ref_flush_cnt));
`else
    check("perf_stall_cnt", 32'(perf_stall_cnt), 32'd0);
    check("perf_flush_cnt", 32'(perf_flush_cnt), 32'd0);
`endif
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1;
    {branch_d, pc_src_d, rf_we_e, memtoreg_e, md_start_e} = 5'b0;
    {rf_we_m, memtoreg_m, rf_we_w, dmem_wait} = 4'b0;
    {rs_d, rt_d, rs_e, rt_e, rf_a_e, rf_a_m, rf_a_w} = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    step();

    // M/W forwarding priority, W only, zero register.
    rf_a_m = 5'd3; rf_a_w = 5'd3; rf_we_m = 1'b1; rf_we_w = 1'b1; rs_e = 5'd3; rt_e = 5'd3;
    step();
    rf_we_m = 1'b0;
    step();
    rs_e = 5'd0;
    step();
    idle_inputs();

    // Load-use stall, then destination r0 gives none.
    memtoreg_e = 1'b1; rf_we_e = 1'b1; rf_a_e = 5'd5; rt_d = 5'd5;
    step();
    rf_a_e = 5'd0;
    step();
    idle_inputs();

    // Branch dependent on E, then on a load in M, then resolved.
    branch_d = 1'b1; rs_d = 5'd7; rf_a_e = 5'd7; rf_we_e = 1'b1;
    step();
    rf_a_e = 5'd0; rf_we_e = 1'b0; memtoreg_m = 1'b1; rf_a_m = 5'd7;
    step();
    memtoreg_m = 1'b0; rf_a_m = 5'd0; pc_src_d = 1'b1;
    step();
    idle_inputs();

    // Mul/div held high: two back-to-back holds with a release between.
    md_start_e = 1'b1;
    for (int i = 0; i < 2 * (MD_LAT + 1); i++) step();
    idle_inputs();
    step();

    // Memory wait during the second hold cycle extends the hold.
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    dmem_wait = 1'b1;
    step();
    dmem_wait = 1'b0;
    for (int i = 0; i < MD_LAT + 1; i++) step();

    // Reset in the middle of a hold aborts it.
    md_start_e = 1'b1;
    step();
    md_start_e = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();

    // Randomized traffic over a small register range to provoke matches.
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 79) != 0);
      branch_d   = 1'($urandom_range(0, 1));
      pc_src_d   = ($urandom_range(0, 3) == 0);
      rs_d       = REG_AW'($urandom_range(0, 3));
      rt_d       = REG_AW'($urandom_range(0, 3));
      rs_e       = REG_AW'($urandom_range(0, 3));
      rt_e       = REG_AW'($urandom_range(0, 3));
      rf_a_e     = REG_AW'($urandom_range(0, 3));
      rf_a_m     = REG_AW'($urandom_range(0, 3));
      rf_a_w     = REG_AW'($urandom_range(0, 3));
      rf_we_e    = 1'($urandom_range(0, 1));
      rf_we_m    = 1'($urandom_range(0, 1));
      rf_we_w    = 1'($urandom_range(0, 1));
      memtoreg_e = ($urandom_range(0, 2) == 0);
      memtoreg_m = ($urandom_range(0, 2) == 0);
      md_start_e = ($urandom_range(0, 9) == 0);
      dmem_wait  = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
